// File: rtl/shift_unit_pkg.sv
// Shared encodings for the iterative shift unit.
// Op codes, FSM state type and default widths.
package shift_unit_pkg;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_SHAMT_W = 5;

  localparam logic [2:0] OP_SLL = 3'b001;
  localparam logic [2:0] OP_SRL = 3'b010;
  localparam logic [2:0] OP_SRA = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;
  localparam logic [2:0] OP_ROL = 3'b101;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

  function automatic logic op_valid(
    input logic [2:0] op
  );
    return (op >= OP_SLL) && (op <= OP_ROL);
  endfunction

endpackage

// File: rtl/iterative_shift_unit_step.sv
// shift_step: one-bit shift/rotate of a vector selected by op.
// Ports: din in, op select, dout = stepped din (pass-through on bad op).
module shift_step
  import shift_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] din,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] dout
);

  always_comb begin
    dout = din;
    case (op)
      OP_SLL: dout = {din[WIDTH-2:0], 1'b0};
      OP_SRL: dout = {1'b0, din[WIDTH-1:1]};
      OP_SRA: dout = {din[WIDTH-1], din[WIDTH-1:1]};
      OP_ROR: dout = {din[0], din[WIDTH-1:1]};
      OP_ROL: dout = {din[WIDTH-2:0], din[WIDTH-1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/iterative_shift_unit.sv
// Multi-cycle shifter: latches operand+amount, shifts 1 bit/clk,
// pulses done, holds result. SHIFT_BARREL_EN: single-cycle barrel.
// Ports: clk, reset (sync, low), start, op, data_in, shamt -> busy, done, result.
module iterative_shift_unit
  import shift_unit_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;

`ifdef SHIFT_BARREL_EN

  // Log2 chain: stage k shifts by 2**k when shamt[k] is set.
  logic [SHAMT_W:0][WIDTH-1:0] stage;

  assign stage[0] = data_in;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_barrel
    localparam int N = 1 << k;
    logic [WIDTH-1:0] sh;

    always_comb begin
      sh = stage[k];
      case (op)
        OP_SLL: sh = stage[k] << N;
        OP_SRL: sh = stage[k] >> N;
        OP_SRA: sh = WIDTH'($signed(stage[k]) >>> N);
        OP_ROR: sh = (stage[k] >> N)
                   | (stage[k] << (WIDTH - N));
        OP_ROL: sh = (stage[k] << N)
                   | (stage[k] >> (WIDTH - N));
        default: sh = stage[k];
      endcase
    end

    assign stage[k+1] = shamt[k] ? sh : stage[k];
  end

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          result_d = stage[SHAMT_W];
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
    end
  end

`else

  logic [SHAMT_W-1:0] count_q, count_d;
  logic [2:0]         op_q, op_d;
  logic [WIDTH-1:0]   step_out;

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .din  (result_q),
    .op   (op_q),
    .dout (step_out)
  );

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    count_d  = count_q;
    op_d     = op_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op;
          result_d = data_in;
          count_d  = shamt;
          // Zero amount or unknown op: nothing to shift.
          if ((shamt != '0) && op_valid(op)) begin
            state_d = SHIFT;
          end else begin
            state_d = DONE;
          end
        end
      end
      SHIFT: begin
        result_d = step_out;
        count_d  = count_q - 1'b1;
        if (count_q == SHAMT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      count_q  <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      count_q  <= count_d;
      op_q     <= op_d;
    end
  end

`endif

  assign busy   = (state_q == SHIFT) || (state_q == DONE);
  assign done   = (state_q == DONE);
  assign result = result_q;

endmodule
